// File: rtl/complex_add_pipe_32b.sv
// complex_add_pipe_32b
// Two-stage pipelined complex adder, R = A + B, on packed complex words.
// Bits [31:16] hold the real part and bits [15:0] the imaginary part. Each
// 16-bit part is added on its own carry chain, so no carry crosses bit 15->16.
// Each part's add is split at LOW_W: stage 1 adds the low slice and registers
// its carry, and stage 2 adds the upper slice plus that carry. This keeps the
// carry chain between any two registers short.
// A valid/ready handshake lets downstream stall the pipe without losing data.
module complex_add_pipe_32b #(
  parameter int LOW_W = 8,   // split position inside each part, legal 1..15
  parameter int DW    = 16   // part width; the 32-bit packing depends on 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] A32,
  input  logic [31:0] B32,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] R32,
  output logic [1:0]  C_OUT32
);

  localparam int HI_W = DW - LOW_W;

  logic s1_valid_reg;
  logic s2_valid_reg;
  logic stall;
  logic advance;
  logic in_xfer;

  // The pipe only stalls when a real result is held and blocked. A bubble in
  // stage 2 never blocks, so the pipe keeps advancing whatever OUT_READY is.
  assign stall     = s2_valid_reg & ~OUT_READY;
  assign advance   = ~stall;
  assign IN_READY  = advance;
  assign in_xfer   = IN_VALID & advance;
  assign OUT_VALID = s2_valid_reg;

  // Valid flags: both stages move together when not stalled. Stage 1 takes in
  // a bubble when there is no input transfer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else if (advance) begin
      s1_valid_reg <= in_xfer;
      s2_valid_reg <= s1_valid_reg;
    end
  end

  // One slice per complex part: gi = 0 is imaginary [15:0], gi = 1 is real [31:16].
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_part
      logic [LOW_W-1:0] a_lo;
      logic [LOW_W-1:0] b_lo;
      logic [HI_W-1:0]  a_hi;
      logic [HI_W-1:0]  b_hi;
      logic [LOW_W:0]   lo_sum_next;
      logic [HI_W:0]    hi_sum_next;

      logic [LOW_W-1:0] s1_lo_sum_reg;
      logic             s1_lo_carry_reg;
      logic [HI_W-1:0]  s1_a_hi_reg;
      logic [HI_W-1:0]  s1_b_hi_reg;

      logic [DW-1:0]    s2_r_reg;
      logic             s2_c_reg;

      assign a_lo = A32[gi*DW +: LOW_W];
      assign b_lo = B32[gi*DW +: LOW_W];
      assign a_hi = A32[gi*DW+LOW_W +: HI_W];
      assign b_hi = B32[gi*DW+LOW_W +: HI_W];

      // Low slice add. The extra top bit is the carry handed to stage 2.
      assign lo_sum_next = {1'b0, a_lo} + {1'b0, b_lo};

      // Upper slice add, including the registered low carry. Its top bit is
      // the carry-out of bit 15 of this part.
      assign hi_sum_next = {1'b0, s1_a_hi_reg} + {1'b0, s1_b_hi_reg}
                         + {{HI_W{1'b0}}, s1_lo_carry_reg};

      // Stage 1 data: capture the low partial sum and the upper operand slices.
      // Capture happens only on an accepted pair, so the registers stay zero
      // until the first pair is accepted.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          s1_lo_sum_reg   <= '0;
          s1_lo_carry_reg <= 1'b0;
          s1_a_hi_reg     <= '0;
          s1_b_hi_reg     <= '0;
        end else if (in_xfer) begin
          s1_lo_sum_reg   <= lo_sum_next[LOW_W-1:0];
          s1_lo_carry_reg <= lo_sum_next[LOW_W];
          s1_a_hi_reg     <= a_hi;
          s1_b_hi_reg     <= b_hi;
        end
      end

      // Stage 2 data: finish the add and hold the result for the output.
      // Only real operands are loaded. The outputs therefore keep their last
      // result through bubbles, and read zero until the first result.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          s2_r_reg <= '0;
          s2_c_reg <= 1'b0;
        end else if (advance && s1_valid_reg) begin
          {s2_c_reg, s2_r_reg} <= {hi_sum_next, s1_lo_sum_reg};
        end
      end

      assign R32[gi*DW +: DW] = s2_r_reg;
      assign C_OUT32[gi]      = s2_c_reg;
    end
  endgenerate

endmodule

// File: tb/tb_complex_add_pipe_32b.sv
// tb_complex_add_pipe_32b
// Directed bench for the pipelined complex adder. It covers reset state,
// hand-computed sums, split and overflow carries, a backpressure stream, a
// full-rate random stream and a reset during operation.
module tb_complex_add_pipe_32b;

  logic        CLK       = 1'b0;
  logic        RST_N     = 1'b0;
  logic        IN_VALID  = 1'b0;
  logic        IN_READY;
  logic [31:0] A32       = '0;
  logic [31:0] B32       = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [31:0] R32;
  logic [1:0]  C_OUT32;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] sa   [64];
  logic [31:0] sb   [64];
  logic [31:0] se_r [64];
  logic [1:0]  se_c [64];

  complex_add_pipe_32b dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A32       (A32),
    .B32       (B32),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .R32       (R32),
    .C_OUT32   (C_OUT32)
  );

  always #5 CLK = ~CLK;

  // Compare one observed value with its expected value, count it, and print
  // one line.
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Reference: two independent 16-bit adds, as {c_re, c_im, r_re, r_im}.
  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [16:0] re;
    logic [16:0] im;
    re = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    im = {1'b0, a[15:0]}  + {1'b0, b[15:0]};
    return {re[16], im[16], re[15:0], im[15:0]};
  endfunction

  // Send one pair into an idle pipe and check latency, result and the bubble after it.
  task automatic single_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic [1:0] ec);
    @(negedge CLK);
    OUT_READY = 1'b1;
    IN_VALID  = 1'b1;
    A32 = a;
    B32 = b;
    @(negedge CLK);
    IN_VALID = 1'b0;
    A32 = '0;
    B32 = '0;
    check_val($sformatf("%s valid@1", tag), OUT_VALID, 1'b0);
    @(negedge CLK);
    check_val($sformatf("%s valid@2", tag), OUT_VALID, 1'b1);
    check_val($sformatf("%s r32", tag), R32, er);
    check_val($sformatf("%s c_out", tag), C_OUT32, ec);
    @(negedge CLK);
    check_val($sformatf("%s valid@3", tag), OUT_VALID, 1'b0);
  endtask

  // Stream n pairs from sa/sb and expect se_r/se_c in order. OUT_READY is
  // dropped for stall_len cycles starting at cycle stall_at.
  task automatic run_stream(input string tag, input int n, input int stall_at,
                            input int stall_len, input int exp_cycles);
    int          in_idx     = 0;
    int          out_idx    = 0;
    int          cyc        = 0;
    int          stalls     = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_r     = '0;
    logic [1:0]  prev_c     = '0;
    bit          ov;
    bit          ir;
    while (out_idx < n && cyc < 300) begin
      @(negedge CLK);
      OUT_READY = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (in_idx < n) begin
        IN_VALID = 1'b1;
        A32 = sa[in_idx];
        B32 = sb[in_idx];
      end else begin
        IN_VALID = 1'b0;
        A32 = '0;
        B32 = '0;
      end
      #1;
      ov = OUT_VALID;
      ir = IN_READY;
      check_val($sformatf("%s in_ready c%0d", tag, cyc), ir, !(ov && !OUT_READY));
      if (prev_stall) begin
        check_val($sformatf("%s hold r32 c%0d", tag, cyc), R32, prev_r);
        check_val($sformatf("%s hold c_out c%0d", tag, cyc), C_OUT32, prev_c);
      end
      if (ov && !OUT_READY) stalls++;
      if (ov && OUT_READY) begin
        check_val($sformatf("%s r32 #%0d", tag, out_idx), R32, se_r[out_idx]);
        check_val($sformatf("%s c_out #%0d", tag, out_idx), C_OUT32, se_c[out_idx]);
        out_idx++;
      end
      if (IN_VALID && ir) in_idx++;
      prev_stall = ov && !OUT_READY;
      prev_r = R32;
      prev_c = C_OUT32;
      cyc++;
    end
    @(negedge CLK);
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    A32 = '0;
    B32 = '0;
    check_val($sformatf("%s results", tag), out_idx, n);
    check_val($sformatf("%s cycles", tag), cyc, exp_cycles);
    check_val($sformatf("%s stall cycles", tag), stalls, stall_len);
    check_val($sformatf("%s drained", tag), OUT_VALID, 1'b0);
  endtask

  initial begin
    logic [33:0] m;

    // Reset state while RST_N is held low.
    repeat (2) @(negedge CLK);
    check_val("reset out_valid", OUT_VALID, 1'b0);
    check_val("reset r32", R32, 32'h0);
    check_val("reset c_out", C_OUT32, 2'b00);
    check_val("reset in_ready", IN_READY, 1'b1);
    RST_N = 1'b1;

    // Directed sums.
    single_op("basic", 32'h0003_0004, 32'h0001_0002, 32'h0004_0006, 2'b00);
    single_op("split", 32'h00FF_01FF, 32'h0001_0001, 32'h0100_0200, 2'b00);
    single_op("wrap1", 32'hFFFF_8000, 32'h0001_8000, 32'h0000_0000, 2'b11);
    single_op("wrap2", 32'h8000_0001, 32'h8000_FFFF, 32'h0000_0000, 2'b11);
    single_op("signov", 32'h7FFF_0000, 32'h0001_0000, 32'h8000_0000, 2'b00);

    // Backpressure stream: 6 pairs with a 3-cycle stall mid-stream.
    for (int k = 0; k < 6; k++) begin
      sa[k]   = (k << 16) | k;
      sb[k]   = 32'h0001_0001;
      se_r[k] = ((k + 1) << 16) | (k + 1);
      se_c[k] = 2'b00;
    end
    run_stream("bp", 6, 4, 3, 11);

    // Full-rate stream of 64 random pairs, led by an all-ones corner case.
    for (int k = 0; k < 64; k++) begin
      sa[k] = (k == 0) ? 32'hFFFF_FFFF : $urandom();
      sb[k] = (k == 0) ? 32'hFFFF_FFFF : $urandom();
      m = ref_add(sa[k], sb[k]);
      se_r[k] = m[31:0];
      se_c[k] = m[33:32];
    end
    run_stream("tput", 64, -1, 0, 66);

    // Reset during operation: two pairs in flight, reset asserted between edges.
    @(negedge CLK);
    IN_VALID = 1'b1;
    A32 = 32'hFFFF_0001;
    B32 = 32'h0001_0001;
    @(negedge CLK);
    A32 = 32'h1234_0010;
    B32 = 32'h1111_0020;
    @(negedge CLK);
    IN_VALID = 1'b0;
    A32 = '0;
    B32 = '0;
    check_val("rst pre valid", OUT_VALID, 1'b1);
    check_val("rst pre r32", R32, 32'h0000_0002);
    check_val("rst pre c_out", C_OUT32, 2'b10);
    #2;
    RST_N = 1'b0;
    #1;
    check_val("rst async valid", OUT_VALID, 1'b0);
    check_val("rst async r32", R32, 32'h0);
    check_val("rst async c_out", C_OUT32, 2'b00);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check_val($sformatf("rst no stale c%0d", k), OUT_VALID, 1'b0);
    end
    single_op("post_rst", 32'h0002_0002, 32'h0003_0003, 32'h0005_0005, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
